// File: rtl/tbd_accel_ctrl_if.sv
// OBI request/response bundle for the tbd_accel control port.
// The master side issues requests. The slave side grants them and returns one response per accepted request.
interface tbd_accel_ctrl_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 1
);
    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    logic                   rvalid;
    logic [DataWidth-1:0]   rdata;
    logic                   err;
    logic [IdWidth-1:0]     rid;

    modport master (
        output req, addr, we, be, wdata, aid,
        input  gnt, rvalid, rdata, err, rid
    );

    modport slave (
        input  req, addr, we, be, wdata, aid,
        output gnt, rvalid, rdata, err, rid
    );
endinterface

// File: rtl/tbd_accel_ctrl.sv
// MMIO register file and run sequencer for the tbd_accel pattern-match engine.
// A software START launches one run. The block then waits for done, or for a timeout or an abort.
// It captures the match result, counts WAIT cycles and raises a level interrupt.
module tbd_accel_ctrl #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 1,
    parameter int LenWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tbd_accel_ctrl_if.slave      obi,
    output logic                 accel_start_o,
    output logic                 accel_abort_o,
    output logic [AddrWidth-1:0] accel_base_o,
    output logic [LenWidth-1:0]  accel_len_o,
    input  logic                 accel_done_i,
    input  logic                 accel_match_i,
    output logic                 irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_e;

    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_STATUS = 3'd1;
    localparam logic [2:0] SEL_BASE   = 3'd2;
    localparam logic [2:0] SEL_LEN    = 3'd3;
    localparam logic [2:0] SEL_TMO    = 3'd4;
    localparam logic [2:0] SEL_CYCLES = 3'd5;

    localparam logic [DataWidth-1:0] BAD_DATA = DataWidth'(32'hBADC_AB1E);

    state_e                 state_q, state_d;
    logic                   irq_en_q, irq_en_d;
    logic [DataWidth-1:0]   base_q, base_d;
    logic [LenWidth-1:0]    len_q, len_d;
    logic [DataWidth-1:0]   tmo_q, tmo_d;
    logic [DataWidth-1:0]   cycles_q, cycles_d;
    logic                   done_q, done_d;
    logic                   match_q, match_d;
    logic                   timeout_q, timeout_d;
    logic                   start_cmd_q, start_cmd_d;
    logic                   abort_cmd_q, abort_cmd_d;
    logic                   irq_q, irq_d;
    logic                   rvalid_q, rvalid_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [IdWidth-1:0]     rid_q, rid_d;

    logic                   busy;
    logic                   bus_wr;
    logic [2:0]             sel;
    logic [DataWidth:0]     cycles_inc;
    logic                   tmo_hit;
    logic [DataWidth-1:0]   len_wide;

    // Merge write data into an old register value, one byte lane per enable bit.
    function automatic logic [DataWidth-1:0] apply_be(
        input logic [DataWidth-1:0]   old_v,
        input logic [DataWidth-1:0]   new_v,
        input logic [DataWidth/8-1:0] be
    );
        logic [DataWidth-1:0] r;
        r = old_v;
        for (int i = 0; i < DataWidth/8; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return r;
    endfunction

    assign obi.gnt      = obi.req;
    assign obi.rvalid   = rvalid_q;
    assign obi.rdata    = rdata_q;
    assign obi.err      = err_q;
    assign obi.rid      = rid_q;

    assign sel          = obi.addr[4:2];
    assign bus_wr       = obi.req & obi.we;
    assign busy         = (state_q != ST_IDLE);
    assign cycles_inc   = {1'b0, cycles_q} + (DataWidth+1)'(1);
    assign tmo_hit      = (tmo_q != '0) && (cycles_inc == {1'b0, tmo_q});

    assign accel_base_o = AddrWidth'(base_q);
    assign accel_len_o  = len_q;
    assign irq_o        = irq_q;

    // State register; reset drops the sequencer straight back to idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A done in WAIT outranks a timeout, and a timeout outranks a software abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_cmd_q && (len_q != '0)) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (accel_done_i || tmo_hit || abort_cmd_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accelerator pulses. Abort is suppressed whenever done arrives in the same cycle.
    always_comb begin
        accel_start_o = (state_q == ST_LAUNCH);
        accel_abort_o = (state_q == ST_WAIT) && !accel_done_i && (tmo_hit || abort_cmd_q);
    end

    // Register writes first, then hardware status updates, so that a hardware set beats a same-cycle W1C.
    always_comb begin
        irq_en_d    = irq_en_q;
        base_d      = base_q;
        len_d       = len_q;
        tmo_d       = tmo_q;
        cycles_d    = cycles_q;
        done_d      = done_q;
        match_d     = match_q;
        timeout_d   = timeout_q;
        start_cmd_d = 1'b0;
        abort_cmd_d = 1'b0;
        len_wide    = apply_be(DataWidth'(len_q), obi.wdata, obi.be);
        irq_d       = irq_en_q & (done_q | timeout_q);

        if (bus_wr) begin
            case (sel)
                SEL_CTRL: begin
                    if (obi.be[0]) begin
                        irq_en_d    = obi.wdata[1];
                        start_cmd_d = obi.wdata[0] & ~busy;
                        abort_cmd_d = obi.wdata[2];
                    end
                end
                SEL_STATUS: begin
                    if (obi.be[0]) begin
                        if (obi.wdata[1]) done_d    = 1'b0;
                        if (obi.wdata[3]) timeout_d = 1'b0;
                    end
                end
                SEL_BASE: if (!busy) base_d = apply_be(base_q, obi.wdata, obi.be);
                SEL_LEN:  if (!busy) len_d  = len_wide[LenWidth-1:0];
                SEL_TMO:  if (!busy) tmo_d  = apply_be(tmo_q, obi.wdata, obi.be);
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_cmd_q) begin
                    if (len_q != '0) begin
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        match_d   = 1'b0;
                        cycles_d  = '0;
                    end else begin
                        done_d  = 1'b1;
                        match_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                cycles_d = (cycles_q == '1) ? cycles_q : cycles_inc[DataWidth-1:0];
                if (accel_done_i) begin
                    done_d  = 1'b1;
                    match_d = accel_match_i;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Response path: every granted request yields exactly one response on the next cycle.
    always_comb begin
        rvalid_d = obi.req;
        rid_d    = obi.req ? obi.aid : '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        if (obi.req) begin
            if (obi.we) begin
                case (sel)
                    SEL_BASE, SEL_LEN, SEL_TMO: err_d = busy;
                    SEL_CTRL, SEL_STATUS, SEL_CYCLES: err_d = 1'b0;
                    default: begin
                        err_d   = 1'b1;
                        rdata_d = BAD_DATA;
                    end
                endcase
            end else begin
                case (sel)
                    SEL_CTRL:   rdata_d = DataWidth'({irq_en_q, 1'b0});
                    SEL_STATUS: rdata_d = DataWidth'({timeout_q, match_q, done_q, busy});
                    SEL_BASE:   rdata_d = base_q;
                    SEL_LEN:    rdata_d = DataWidth'(len_q);
                    SEL_TMO:    rdata_d = tmo_q;
                    SEL_CYCLES: rdata_d = cycles_q;
                    default: begin
                        err_d   = 1'b1;
                        rdata_d = BAD_DATA;
                    end
                endcase
            end
        end
    end

    // Register file, command strobes, interrupt and bus response flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q    <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            tmo_q       <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            timeout_q   <= 1'b0;
            start_cmd_q <= 1'b0;
            abort_cmd_q <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rid_q       <= '0;
        end else begin
            irq_en_q    <= irq_en_d;
            base_q      <= base_d;
            len_q       <= len_d;
            tmo_q       <= tmo_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            match_q     <= match_d;
            timeout_q   <= timeout_d;
            start_cmd_q <= start_cmd_d;
            abort_cmd_q <= abort_cmd_d;
            irq_q       <= irq_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rid_q       <= rid_d;
        end
    end

endmodule

// File: tb/tb_tbd_accel_ctrl.sv
// Directed bench for tbd_accel_ctrl: register access, run sequencing, timeout, collisions and reset.
module tb_tbd_accel_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int LW = 16;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_BASE   = 32'h08;
    localparam logic [31:0] A_LEN    = 32'h0C;
    localparam logic [31:0] A_TMO    = 32'h10;
    localparam logic [31:0] A_CYCLES = 32'h14;

    logic          clk = 1'b0;
    logic          rst;
    logic          accel_start;
    logic          accel_abort;
    logic [AW-1:0] accel_base;
    logic [LW-1:0] accel_len;
    logic          accel_done;
    logic          accel_match;
    logic          irq;

    int compare_count  = 0;
    int mismatch_count = 0;
    int start_count    = 0;
    int abort_count    = 0;
    int s0;
    int a0;

    tbd_accel_ctrl_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) obi_bus ();

    tbd_accel_ctrl #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .LenWidth(LW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .obi           (obi_bus),
        .accel_start_o (accel_start),
        .accel_abort_o (accel_abort),
        .accel_base_o  (accel_base),
        .accel_len_o   (accel_len),
        .accel_done_i  (accel_done),
        .accel_match_i (accel_match),
        .irq_o         (irq)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Count accelerator pulses mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (accel_start === 1'b1) start_count++;
        if (accel_abort === 1'b1) abort_count++;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One OBI transfer, issued 1 time unit after a rising edge; the response is sampled 1 unit after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic aid,
                                 output logic [31:0] rdata, output logic err);
        obi_bus.req   = 1'b1;
        obi_bus.we    = we;
        obi_bus.addr  = addr;
        obi_bus.wdata = wdata;
        obi_bus.be    = be;
        obi_bus.aid   = aid;
        @(posedge clk);
        #1;
        obi_bus.req = 1'b0;
        obi_bus.we  = 1'b0;
        checkOutput("rvalid", {31'b0, obi_bus.rvalid}, 32'h1);
        checkOutput("rid", {31'b0, obi_bus.rid}, {31'b0, aid});
        rdata = obi_bus.rdata;
        err   = obi_bus.err;
    endtask

    task automatic writeCheck(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        applyStimulus(1'b1, addr, data, be, 1'b1, rd, e);
        checkOutput(tag, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        logic [31:0] rd;
        logic        e;
        applyStimulus(1'b0, addr, 32'h0, 4'hF, 1'b0, rd, e);
        checkOutput({tag, "_err"}, {31'b0, e}, 32'h0);
        checkOutput(tag, rd, expected);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;

        rst           = 1'b1;
        accel_done    = 1'b0;
        accel_match   = 1'b0;
        obi_bus.req   = 1'b0;
        obi_bus.we    = 1'b0;
        obi_bus.addr  = '0;
        obi_bus.wdata = '0;
        obi_bus.be    = '0;
        obi_bus.aid   = '0;

        // Reset state.
        #2;
        checkOutput("rst_start", {31'b0, accel_start}, 32'h0);
        checkOutput("rst_abort", {31'b0, accel_abort}, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_rvalid", {31'b0, obi_bus.rvalid}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        readCheck("status_after_rst", A_STATUS, 32'h0);

        // Basic run: done with match in the fifth WAIT cycle.
        writeCheck("base_wr_err", A_BASE, 32'h1000_0000, 4'hF, 1'b0);
        writeCheck("len_wr_err", A_LEN, 32'd8, 4'hF, 1'b0);
        checkOutput("base_o", accel_base, 32'h1000_0000);
        checkOutput("len_o", {16'b0, accel_len}, 32'd8);
        s0 = start_count;
        writeCheck("ctrl_start_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        checkOutput("start_c1", {31'b0, accel_start}, 32'h0);
        tick(1);
        checkOutput("start_c2", {31'b0, accel_start}, 32'h1);
        tick(1);
        checkOutput("start_c3", {31'b0, accel_start}, 32'h0);
        tick(4);
        accel_done  = 1'b1;
        accel_match = 1'b1;
        #1;
        checkOutput("basic_no_abort", {31'b0, accel_abort}, 32'h0);
        tick(1);
        accel_done  = 1'b0;
        accel_match = 1'b0;
        readCheck("basic_status", A_STATUS, 32'h6);
        checkOutput("basic_irq", {31'b0, irq}, 32'h1);
        readCheck("basic_cycles", A_CYCLES, 32'd5);
        checkOutput("basic_start_pulses", start_count - s0, 32'd1);
        writeCheck("w1c_err", A_STATUS, 32'h2, 4'hF, 1'b0);
        tick(1);
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
        readCheck("status_after_w1c", A_STATUS, 32'h4);

        // Timeout after four WAIT cycles.
        writeCheck("tmo4_wr_err", A_TMO, 32'd4, 4'hF, 1'b0);
        a0 = abort_count;
        writeCheck("tmo_start_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        tick(4);
        checkOutput("tmo_abort_c3", {31'b0, accel_abort}, 32'h0);
        tick(1);
        checkOutput("tmo_abort_c4", {31'b0, accel_abort}, 32'h1);
        tick(1);
        readCheck("tmo_status", A_STATUS, 32'h8);
        readCheck("tmo_cycles", A_CYCLES, 32'd4);
        checkOutput("tmo_abort_pulses", abort_count - a0, 32'd1);
        checkOutput("tmo_irq", {31'b0, irq}, 32'h1);

        // Done and timeout in the same cycle: done wins, no abort.
        writeCheck("tmo3_wr_err", A_TMO, 32'd3, 4'hF, 1'b0);
        a0 = abort_count;
        writeCheck("coll_start_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        tick(4);
        accel_done  = 1'b1;
        accel_match = 1'b1;
        #1;
        checkOutput("coll_no_abort", {31'b0, accel_abort}, 32'h0);
        tick(1);
        accel_done  = 1'b0;
        accel_match = 1'b0;
        readCheck("coll_status", A_STATUS, 32'h6);
        readCheck("coll_cycles", A_CYCLES, 32'd3);
        checkOutput("coll_abort_pulses", abort_count - a0, 32'd0);

        // Busy protection, ignored second START, then software abort.
        writeCheck("tmo0_wr_err", A_TMO, 32'd0, 4'hF, 1'b0);
        s0 = start_count;
        a0 = abort_count;
        writeCheck("busy_start_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        tick(3);
        writeCheck("busy_len_err", A_LEN, 32'd20, 4'hF, 1'b1);
        writeCheck("busy_start2_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        tick(3);
        readCheck("busy_len", A_LEN, 32'd8);
        readCheck("busy_status", A_STATUS, 32'h1);
        writeCheck("abort_wr_err", A_CTRL, 32'h6, 4'hF, 1'b0);
        checkOutput("sw_abort_pulse", {31'b0, accel_abort}, 32'h1);
        tick(1);
        readCheck("abort_status", A_STATUS, 32'h0);
        checkOutput("busy_start_pulses", start_count - s0, 32'd1);
        checkOutput("busy_abort_pulses", abort_count - a0, 32'd1);

        // Back-to-back transfers with alternating ids.
        obi_bus.req   = 1'b1;
        obi_bus.we    = 1'b1;
        obi_bus.addr  = A_BASE;
        obi_bus.wdata = 32'h1234_5678;
        obi_bus.be    = 4'hF;
        obi_bus.aid   = 1'b0;
        tick(1);
        checkOutput("b2b_rvalid0", {31'b0, obi_bus.rvalid}, 32'h1);
        checkOutput("b2b_rid0", {31'b0, obi_bus.rid}, 32'h0);
        checkOutput("b2b_err0", {31'b0, obi_bus.err}, 32'h0);
        obi_bus.we   = 1'b0;
        obi_bus.aid  = 1'b1;
        tick(1);
        checkOutput("b2b_rvalid1", {31'b0, obi_bus.rvalid}, 32'h1);
        checkOutput("b2b_rid1", {31'b0, obi_bus.rid}, 32'h1);
        checkOutput("b2b_rdata1", obi_bus.rdata, 32'h1234_5678);
        obi_bus.addr = A_LEN;
        obi_bus.aid  = 1'b0;
        tick(1);
        obi_bus.req = 1'b0;
        checkOutput("b2b_rvalid2", {31'b0, obi_bus.rvalid}, 32'h1);
        checkOutput("b2b_rid2", {31'b0, obi_bus.rid}, 32'h0);
        checkOutput("b2b_rdata2", obi_bus.rdata, 32'd8);
        tick(1);
        checkOutput("idle_rvalid", {31'b0, obi_bus.rvalid}, 32'h0);

        // Unmapped offsets.
        applyStimulus(1'b0, 32'h18, 32'h0, 4'hF, 1'b1, rd, e);
        checkOutput("unmapped_rd_err", {31'b0, e}, 32'h1);
        checkOutput("unmapped_rd_data", rd, 32'hBADC_AB1E);
        writeCheck("unmapped_wr_err", 32'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1);
        readCheck("base_untouched", A_BASE, 32'h1234_5678);

        // Byte enables and LEN width.
        writeCheck("be_wr_err", A_BASE, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        checkOutput("be_base_o", accel_base, 32'h1234_FF78);
        writeCheck("len_wide_err", A_LEN, 32'hABCD_0007, 4'hF, 1'b0);
        readCheck("len_upper_zero", A_LEN, 32'h7);

        // START with LEN zero completes immediately without launching.
        writeCheck("len0_wr_err", A_LEN, 32'h0, 4'hF, 1'b0);
        s0 = start_count;
        writeCheck("len0_start_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        tick(4);
        checkOutput("len0_no_start", start_count - s0, 32'd0);
        readCheck("len0_status", A_STATUS, 32'h2);
        checkOutput("len0_irq", {31'b0, irq}, 32'h1);

        // Asynchronous reset in the middle of a WAIT phase.
        writeCheck("rst_len_err", A_LEN, 32'd5, 4'hF, 1'b0);
        writeCheck("rst_run_err", A_CTRL, 32'h3, 4'hF, 1'b0);
        tick(3);
        readCheck("rst_pre_status", A_STATUS, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_rvalid", {31'b0, obi_bus.rvalid}, 32'h0);
        checkOutput("arst_base", accel_base, 32'h0);
        checkOutput("arst_len", {16'b0, accel_len}, 32'h0);
        checkOutput("arst_start", {31'b0, accel_start}, 32'h0);
        checkOutput("arst_abort", {31'b0, accel_abort}, 32'h0);
        checkOutput("arst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        tick(1);
        readCheck("arst_status", A_STATUS, 32'h0);
        readCheck("arst_ctrl", A_CTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
